// File: rtl/mixer_nch.sv
// N-channel stereo mixer: on a downstream pop, fetches one side from every input
// channel, applies per-channel volume, sums and saturates to DATA_W bits.
module mixer_nch #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 24,
  parameter int VOL_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [NUM_CH*2-1:0]         pop_o,
  input  logic [NUM_CH*DATA_W-1:0]    data_i,
  input  logic [NUM_CH*2*VOL_W-1:0]   vol_i,
  input  logic [1:0]                  pop_i,
  output logic [DATA_W-1:0]           data_o,
  output logic [1:0]                  ack_o,
  output logic                        clip_o,
  output logic                        ovr_o,
  input  logic                        clr_i
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = DATA_W + VOL_W + 1;
  localparam int AW = PW + $clog2(NUM_CH);
  localparam logic signed [AW-1:0] SMAX = AW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, OUT} state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          ch, ch_n;
  logic                   side, side_n;
  logic                   fl, fl_n;
  logic [1:0]             pend, pend_n, req;
  logic                   ovr_set, acc_clr, sel, clip_set;
  logic                   rd_vld, prod_vld;
  logic [CW-1:0]          rd_ch;
  logic signed [DATA_W-1:0] samp;
  logic [VOL_W-1:0]       vol;
  logic signed [PW-1:0]   prod, prod_n;
  logic signed [AW-1:0]   acc, y;
  logic [DATA_W-1:0]      sat_val;

  // Control: a pop_i seen in IDLE is served in the same cycle, so it never
  // touches pending unless that side was already pending.
  always_comb begin
    state_n  = state;
    ch_n     = ch;
    side_n   = side;
    fl_n     = fl;
    acc_clr  = 1'b0;
    pop_o    = '0;
    ovr_set  = 1'b0;
    req      = pend | pop_i;
    pend_n   = pend | pop_i;
    sel      = ~req[0];
    for (int unsigned x = 0; x < 2; x++) begin
      if (state != IDLE && side == x[0]) begin
        pend_n[x] = pend[x];
        if (pop_i[x]) ovr_set = 1'b1;
      end else if (pop_i[x] && pend[x]) begin
        ovr_set = 1'b1;
      end
    end
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          side_n      = sel;
          pend_n[sel] = pend[sel] & pop_i[sel];
          acc_clr     = 1'b1;
          ch_n        = '0;
          state_n     = RUN;
        end
      end
      RUN: begin
        pop_o[int'(ch) * 2 + int'(side)] = 1'b1;
        if (ch == CW'(NUM_CH - 1)) begin
          fl_n    = 1'b0;
          state_n = FLUSH;
        end else begin
          ch_n = ch + 1'b1;
        end
      end
      FLUSH: begin
        fl_n = 1'b1;
        if (fl) state_n = OUT;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    samp   = data_i[int'(rd_ch) * DATA_W +: DATA_W];
    vol    = vol_i[(int'(rd_ch) * 2 + int'(side)) * VOL_W +: VOL_W];
    prod_n = PW'(samp) * PW'($signed({1'b0, vol}));
    y      = acc >>> (VOL_W - 1);
    clip_set = 1'b0;
    if (y > SMAX) begin
      sat_val  = SMAX[DATA_W-1:0];
      clip_set = 1'b1;
    end else if (y < SMIN) begin
      sat_val  = SMIN[DATA_W-1:0];
      clip_set = 1'b1;
    end else begin
      sat_val  = y[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ch       <= '0;
      side     <= 1'b0;
      fl       <= 1'b0;
      pend     <= '0;
      rd_vld   <= 1'b0;
      rd_ch    <= '0;
      prod_vld <= 1'b0;
      prod     <= '0;
      acc      <= '0;
      data_o   <= '0;
      ack_o    <= '0;
      clip_o   <= 1'b0;
      ovr_o    <= 1'b0;
    end else begin
      state    <= state_n;
      ch       <= ch_n;
      side     <= side_n;
      fl       <= fl_n;
      pend     <= pend_n;
      rd_vld   <= (state == RUN);
      rd_ch    <= ch;
      prod_vld <= rd_vld;
      prod     <= prod_n;
      if (acc_clr)       acc <= '0;
      else if (prod_vld) acc <= acc + AW'(prod);
      ack_o <= '0;
      if (state == OUT) begin
        data_o      <= sat_val;
        ack_o[side] <= 1'b1;
      end
      if (state == OUT && clip_set) clip_o <= 1'b1;
      else if (clr_i)               clip_o <= 1'b0;
      if (ovr_set)    ovr_o <= 1'b1;
      else if (clr_i) ovr_o <= 1'b0;
    end
  end

endmodule
